// File: rtl/store_buffer_pkg.sv
// Shared definitions for the store buffer: default depth, word-address width
// and the layout of one pending-store entry.
package store_buffer_pkg;

   localparam int DEFAULT_DEPTH = 4;
   localparam int WADDR_W       = 30;

   typedef struct packed {
      logic               valid;
      logic [WADDR_W-1:0] waddr;
      logic [31:0]        data;
   } sb_entry_t;

endpackage

// File: rtl/store_buffer_if.sv
// CPU-side request/response and data-memory port of the store buffer.
// slave is the buffer's view, master is the CPU/memory environment's view.
interface store_buffer_if;

   logic [31:0] addr_i;
   logic        MemWrite_i;
   logic        MemRead_i;
   logic [31:0] wdata_i;
   logic [31:0] rdata_o;
   logic        stall_o;
   logic [31:0] mem_addr_o;
   logic        mem_write_o;
   logic        mem_read_o;
   logic [31:0] mem_wdata_o;
   logic [31:0] mem_rdata_i;

   modport slave (
      input  addr_i, MemWrite_i, MemRead_i, wdata_i, mem_rdata_i,
      output rdata_o, stall_o, mem_addr_o, mem_write_o, mem_read_o, mem_wdata_o
   );

   modport master (
      output addr_i, MemWrite_i, MemRead_i, wdata_i, mem_rdata_i,
      input  rdata_o, stall_o, mem_addr_o, mem_write_o, mem_read_o, mem_wdata_o
   );

endinterface

// File: rtl/store_buffer_match.sv
// Address match for loads: compares the load word address against every
// entry and reports whether any valid entry hits, plus the offset of the
// youngest hit counted backwards from tail (0 = slot just before tail).
module store_buffer_match
   import store_buffer_pkg::*;
#(
   parameter int DEPTH = DEFAULT_DEPTH
) (
   input  sb_entry_t                  entries_i [DEPTH],
   input  logic [$clog2(DEPTH)-1:0]   tail_i,
   input  logic [WADDR_W-1:0]         waddr_i,
   output logic                       hit_o,
   output logic [$clog2(DEPTH)-1:0]   hitOfs_o
);

   localparam int PTR_W = $clog2(DEPTH);

   // Scan oldest-to-youngest so the youngest matching slot is the last one kept.
   always_comb begin
      logic [PTR_W-1:0] idx;
      hit_o    = 1'b0;
      hitOfs_o = '0;
      idx      = '0;
      for (int k = DEPTH - 1; k >= 0; k--) begin
         idx = tail_i - PTR_W'(1) - PTR_W'(k);
         if (entries_i[idx].valid && (entries_i[idx].waddr == waddr_i)) begin
            hit_o    = 1'b1;
            hitOfs_o = PTR_W'(k);
         end
      end
   end

endmodule

// File: rtl/store_buffer.sv
// Store buffer between the CPU EX/MEM stage and data memory. Stores queue in
// a circular FIFO and drain one per cycle whenever the CPU is not reading.
// Loads own the memory port; a load that hits a pending store is either
// forwarded (STORE_BUF_FWD_EN defined) or stalled until the match drains.
module store_buffer
   import store_buffer_pkg::*;
#(
   parameter int DEPTH = DEFAULT_DEPTH
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   store_buffer_if.slave          bus,
   output logic [$clog2(DEPTH):0] count_o,
   output logic                   empty_o
);

   localparam int PTR_W = $clog2(DEPTH);

   sb_entry_t        entries_q [DEPTH];
   logic [PTR_W-1:0] head_q, head_d;
   logic [PTR_W-1:0] tail_q, tail_d;
   logic [PTR_W:0]   count_q, count_d;

   logic             storeReq, loadReq, full, empty;
   logic             hit, pop, accept;
   logic [PTR_W-1:0] hitOfs, hitIdx;

   assign storeReq = bus.MemWrite_i;
   assign loadReq  = bus.MemRead_i & ~bus.MemWrite_i;
   assign full     = (count_q == (PTR_W+1)'(DEPTH));
   assign empty    = (count_q == '0);
   assign hitIdx   = tail_q - PTR_W'(1) - hitOfs;

   store_buffer_match #(.DEPTH(DEPTH)) u_match (
      .entries_i (entries_q),
      .tail_i    (tail_q),
      .waddr_i   (bus.addr_i[31:2]),
      .hit_o     (hit),
      .hitOfs_o  (hitOfs)
   );

   // Memory-port arbitration, load response and stall; all quiet while in reset.
   always_comb begin
      bus.stall_o     = 1'b0;
      bus.rdata_o     = '0;
      bus.mem_addr_o  = '0;
      bus.mem_write_o = 1'b0;
      bus.mem_read_o  = 1'b0;
      bus.mem_wdata_o = '0;
      pop             = 1'b0;
      if (rst_i) begin
         if (loadReq && hit) begin
`ifdef STORE_BUF_FWD_EN
            bus.rdata_o = entries_q[hitIdx].data;
            pop         = 1'b1;
`else
            // While stalled the CPU ignores rdata_o; show the youngest match anyway.
            bus.rdata_o = entries_q[hitIdx].data;
            bus.stall_o = 1'b1;
            pop         = 1'b1;
`endif
         end else if (loadReq) begin
            bus.mem_read_o = 1'b1;
            bus.mem_addr_o = bus.addr_i;
            bus.rdata_o    = bus.mem_rdata_i;
         end else begin
            pop = !empty && !bus.MemRead_i;
         end
         if (pop) begin
            bus.mem_write_o = 1'b1;
            bus.mem_addr_o  = {entries_q[head_q].waddr, 2'b00};
            bus.mem_wdata_o = entries_q[head_q].data;
         end
         if (storeReq && full && !pop) begin
            bus.stall_o = 1'b1;
         end
      end
   end

   assign accept = rst_i && storeReq && (!full || pop);

   // Pointer and occupancy next state; a pop and accept together cancel out.
   always_comb begin
      head_d  = head_q + PTR_W'(pop);
      tail_d  = tail_q + PTR_W'(accept);
      count_d = count_q + (PTR_W+1)'(accept) - (PTR_W+1)'(pop);
   end

   // FIFO state; reset drops all pending stores but leaves entry data as is.
   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            entries_q[i].valid <= 1'b0;
         end
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
         if (pop) begin
            entries_q[head_q].valid <= 1'b0;
         end
         if (accept) begin
            entries_q[tail_q].valid <= 1'b1;
            entries_q[tail_q].waddr <= bus.addr_i[31:2];
            entries_q[tail_q].data  <= bus.wdata_i;
         end
      end
   end

   assign count_o = count_q;
   assign empty_o = empty | ~rst_i;

endmodule

// File: tb/tb_store_buffer.sv
// Self-checking bench for store_buffer. A queue of pending stores acts as the
// scoreboard: accepted stores are pushed, and every memory write the DUT makes
// pops the oldest one and must match it. Honors STORE_BUF_FWD_EN.
module tb_store_buffer;
   import store_buffer_pkg::*;

   localparam int DEPTH = DEFAULT_DEPTH;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] data;
   } pend_t;

   logic                   clk = 1'b0;
   logic                   rst;
   logic [$clog2(DEPTH):0] count;
   logic                   empty;
   logic [31:0]            memArr [256];
   pend_t                  pendQ [$];
   int                     errors = 0;
   int                     checks = 0;

   store_buffer_if sbIf ();

   store_buffer #(.DEPTH(DEPTH)) dut (
      .clk_i   (clk),
      .rst_i   (rst),
      .bus     (sbIf),
      .count_o (count),
      .empty_o (empty)
   );

   always #5 clk = ~clk;

   // Data memory: combinational read, write on the rising edge.
   assign sbIf.mem_rdata_i = memArr[sbIf.mem_addr_o[9:2]];

   always @(posedge clk) begin
      if (sbIf.mem_write_o) memArr[sbIf.mem_addr_o[9:2]] = sbIf.mem_wdata_o;
   end

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   // One CPU cycle: drive, check every output against the model at the falling
   // edge, then advance the model and move to just after the next rising edge.
   task automatic applyStimulus(input logic we, input logic re, input logic [31:0] a,
                                input logic [31:0] d, output logic stallSeen,
                                output logic [31:0] rdataSeen);
      logic        load, hit, full, expStall, expDrain, expRead;
      logic [31:0] expRdata, fwd;
      pend_t       e;
      sbIf.MemWrite_i = we;
      sbIf.MemRead_i  = re;
      sbIf.addr_i     = a;
      sbIf.wdata_i    = d;
      @(negedge clk);
      load = re && !we;
      hit  = 1'b0;
      fwd  = '0;
      if (load) begin
         foreach (pendQ[i]) begin
            if (pendQ[i].addr[31:2] == a[31:2]) begin
               hit = 1'b1;
               fwd = pendQ[i].data;
            end
         end
      end
      full     = (pendQ.size() == DEPTH);
      expStall = 1'b0;
      expDrain = 1'b0;
      expRead  = 1'b0;
      expRdata = '0;
      if (load && hit) begin
`ifdef STORE_BUF_FWD_EN
         expRdata = fwd;
         expDrain = 1'b1;
`else
         expStall = 1'b1;
         expDrain = 1'b1;
`endif
      end else if (load) begin
         expRead  = 1'b1;
         expRdata = memArr[a[9:2]];
      end else begin
         expDrain = (pendQ.size() != 0) && !re;
      end
      if (we && full && !expDrain) expStall = 1'b1;

      checkOutput("count", 32'(count), 32'(pendQ.size()));
      checkOutput("empty", 32'(empty), 32'(pendQ.size() == 0));
      checkOutput("stall", 32'(sbIf.stall_o), 32'(expStall));
      checkOutput("mem_write", 32'(sbIf.mem_write_o), 32'(expDrain));
      checkOutput("mem_read", 32'(sbIf.mem_read_o), 32'(expRead));
      if (!expStall) checkOutput("rdata", sbIf.rdata_o, expRdata);
      if (expRead) checkOutput("rd_addr", sbIf.mem_addr_o, a);
      if (expDrain && pendQ.size() != 0) begin
         e = pendQ.pop_front();
         checkOutput("wr_addr", sbIf.mem_addr_o, {e.addr[31:2], 2'b00});
         checkOutput("wr_data", sbIf.mem_wdata_o, e.data);
      end
      if (we && (!full || expDrain)) pendQ.push_back('{addr: a, data: d});
      stallSeen = sbIf.stall_o;
      rdataSeen = sbIf.rdata_o;
      @(posedge clk);
      #1;
   endtask

   // Hold reset for one edge with an idle CPU; buffer must stay quiet throughout.
   task automatic doReset();
      rst             = 1'b0;
      sbIf.MemWrite_i = 1'b0;
      sbIf.MemRead_i  = 1'b0;
      sbIf.addr_i     = '0;
      sbIf.wdata_i    = '0;
      @(negedge clk);
      checkOutput("rst_stall", 32'(sbIf.stall_o), 32'd0);
      checkOutput("rst_mem_write", 32'(sbIf.mem_write_o), 32'd0);
      checkOutput("rst_empty", 32'(empty), 32'd1);
      @(posedge clk);
      #1;
      rst = 1'b1;
      pendQ.delete();
   endtask

   // Idle until the model says everything has reached memory (bounded).
   task automatic drainAll();
      logic        s;
      logic [31:0] r;
      for (int n = 0; n < 4 * DEPTH && pendQ.size() != 0; n++) begin
         applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, s, r);
      end
      checkOutput("drain_done", 32'(pendQ.size()), 32'd0);
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      logic        s;
      logic [31:0] r, a, d;
      int          nStall, tries;
      for (int i = 0; i < 256; i++) memArr[i] = 32'hC000_0000 | 32'(i);

      doReset();

      // Single store, then idle: it drains to memory and the buffer empties.
      applyStimulus(1'b1, 1'b0, 32'h10, 32'hAAAA_0001, s, r);
      applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, s, r);
      applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, s, r);
      checkOutput("req33_mem", memArr[4], 32'hAAAA_0001);
      checkOutput("req33_count", 32'(count), 32'd0);

      // Miss load returns memory data in the same cycle.
      applyStimulus(1'b0, 1'b1, 32'h10, 32'h0, s, r);
      checkOutput("miss_rdata", r, 32'hAAAA_0001);

      // Fill while reads hold the port, stall on the fifth, then pop+accept.
      for (int i = 0; i < 4; i++) begin
         applyStimulus(1'b1, 1'b1, 32'h100 + 32'(i) * 4, 32'h5000 + 32'(i), s, r);
      end
      checkOutput("req34_count4", 32'(count), 32'd4);
      applyStimulus(1'b1, 1'b1, 32'h110, 32'h5004, s, r);
      checkOutput("req34_stall", 32'(s), 32'd1);
      applyStimulus(1'b1, 1'b0, 32'h110, 32'h5004, s, r);
      checkOutput("req34_nostall", 32'(s), 32'd0);
      checkOutput("req34_count_kept", 32'(count), 32'd4);
      drainAll();

      // Two stores to one word, then a load of that word.
      applyStimulus(1'b1, 1'b1, 32'h40, 32'h1, s, r);
      applyStimulus(1'b1, 1'b1, 32'h40, 32'h2, s, r);
      nStall = 0;
      for (int n = 0; n < 8; n++) begin
         applyStimulus(1'b0, 1'b1, 32'h40, 32'h0, s, r);
         if (!s) break;
         nStall++;
      end
`ifdef STORE_BUF_FWD_EN
      checkOutput("req35_stalls", 32'(nStall), 32'd0);
      checkOutput("req35_rdata", r, 32'h2);
`else
      checkOutput("req36_stalls", 32'(nStall), 32'd2);
      checkOutput("req36_rdata", r, 32'h2);
`endif
      drainAll();

      // Reset with three stores pending: they are dropped, nothing is written.
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b1, 1'b1, 32'h80 + 32'(i) * 4, 32'h7000 + 32'(i), s, r);
      end
      checkOutput("req37_pending", 32'(count), 32'd3);
      doReset();
      checkOutput("req37_count", 32'(count), 32'd0);
      for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, s, r);
      checkOutput("req37_mem_untouched", memArr[32], 32'hC000_0020);

      // Many stores (repeated words included) with idles: pointers wrap, order kept.
      for (int i = 0; i < DEPTH * 3; i++) begin
         d     = $urandom;
         a     = 32'h300 + 32'(i % 5) * 4;
         tries = 0;
         applyStimulus(1'b1, (i % 3) != 2, a, d, s, r);
         while (s && tries < 4) begin
            applyStimulus(1'b1, 1'b0, a, d, s, r);
            tries++;
         end
         if (s) checkOutput("req38_stall_bound", 32'(s), 32'd0);
         if (i % 2 == 1) applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, s, r);
      end
      drainAll();
      checkOutput("final_empty", 32'(empty), 32'd1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
